// File: rtl/alarm_code_tx_pkg.sv
// alarm_tx_pkg: shared types and constants for the alarm code transmitter.
//   tx_state_t  : transmitter FSM states
//   CODE_W      : width of one alarm code
//   DATA_BITS   : data bits per frame
//   FRAME_BITS  : total bits per frame (start + data + optional parity + stop)
// Optional feature macro: ALARM_TX_PARITY_EN (adds an even-parity bit per frame).
package alarm_tx_pkg;

  localparam int CODE_W    = 3;
  localparam int DATA_BITS = 3;

`ifdef ALARM_TX_PARITY_EN
  localparam int FRAME_BITS = 6;
`else
  localparam int FRAME_BITS = 5;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity: ones in the code plus this bit always total an even number.
  function automatic logic even_parity(input logic [CODE_W-1:0] code);
    return ^code;
  endfunction

endpackage

// File: rtl/alarm_code_tx_if.sv
// alarm_code_tx_if: code strobe input plus serial/status outputs of the
// alarm code transmitter.
//   code_in    : alarm code, sampled when code_valid=1
//   code_valid : one-cycle write strobe
//   tx         : serial line, idles high
//   busy       : frame in flight or codes pending
//   overflow   : one-cycle pulse when a code is dropped
//   fifo_count : number of pending codes (excluding the frame in flight)
// Modports: master (code producer), slave (transmitter).
interface alarm_code_tx_if
  import alarm_tx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) ();

  logic [CODE_W-1:0]            code_in;
  logic                         code_valid;
  logic                         tx;
  logic                         busy;
  logic                         overflow;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  modport master (
    output code_in, code_valid,
    input  tx, busy, overflow, fifo_count
  );

  modport slave (
    input  code_in, code_valid,
    output tx, busy, overflow, fifo_count
  );

endinterface

// File: rtl/alarm_code_fifo.sv
// alarm_code_fifo: synchronous FIFO with asynchronous active-low reset.
//   clk, reset : clock and async active-low reset (flushes the FIFO)
//   push_i     : write wdata_i (ignored when full unless popping together)
//   pop_i      : remove head entry (ignored when empty)
//   wdata_i    : write data
//   rdata_o    : head entry (valid when not empty)
//   full_o     : DEPTH entries held
//   empty_o    : no entries held
//   count_o    : number of entries held
module alarm_code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_o || do_pop_s);

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/alarm_code_tx.sv
// alarm_code_tx: buffers 3-bit alarm codes and sends each one as a framed,
// LSB-first serial word: start(0), code[0..2], [even parity], stop(1).
//   clk   : system clock
//   reset : asynchronous active-low reset; aborts any frame, line goes high
//   bus   : alarm_code_tx_if.slave (code_in, code_valid, tx, busy,
//           overflow, fifo_count)
// Parameters: CLKS_PER_BIT (>=2), FIFO_DEPTH (power of 2, >=2).
// Optional feature macro: ALARM_TX_PARITY_EN (adds the PARITY bit/state).
module alarm_code_tx
  import alarm_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  alarm_code_tx_if.slave bus
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]        BIT_LAST  = 2'(DATA_BITS - 1);

  tx_state_t          state_q, state_d;
  logic [BAUD_W-1:0]  baud_q, baud_d;
  logic [1:0]         bit_idx_q, bit_idx_d;
  logic [CODE_W-1:0]  shift_q, shift_d;
`ifdef ALARM_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;

  logic               full_s, empty_s;
  logic [CW-1:0]      count_s;
  logic [CW-1:0]      count_next_s;
  logic [CODE_W-1:0]  head_s;
  logic               bit_done_s;
  logic               pop_s;
  logic               push_s;

  alarm_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (bus.code_in),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign bit_done_s = (baud_q == BAUD_LAST);

  // A new frame starts from IDLE, or straight out of the last STOP cycle so
  // consecutive frames have no idle gap.
  assign pop_s  = !empty_s && ((state_q == IDLE) || ((state_q == STOP) && bit_done_s));
  assign push_s = bus.code_valid && (!full_s || pop_s);

  // Occupancy after this edge, so busy can rise on the write edge itself.
  assign count_next_s = count_s + CW'(push_s) - CW'(pop_s);

  // FSM, baud counter, bit index and shift register state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= {BAUD_W{1'b0}};
      bit_idx_q <= 2'd0;
      shift_q   <= {CODE_W{1'b0}};
`ifdef ALARM_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef ALARM_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Next-state logic: one bit time per state, three in DATA.
  always_comb begin
    state_d   = state_q;
    baud_d    = bit_done_s ? {BAUD_W{1'b0}} : (baud_q + BAUD_W'(1));
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef ALARM_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = {BAUD_W{1'b0}};
        if (pop_s) begin
          state_d = START;
          shift_d = head_s;
`ifdef ALARM_TX_PARITY_EN
          parity_d = even_parity(head_s);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_d   = DATA;
          bit_idx_d = 2'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          shift_d = {1'b0, shift_q[CODE_W-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            bit_idx_d = 2'd0;
`ifdef ALARM_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 2'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef ALARM_TX_PARITY_EN
      PARITY: begin
        if (bit_done_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_done_s) begin
          if (pop_s) begin
            state_d = START;
            shift_d = head_s;
`ifdef ALARM_TX_PARITY_EN
            parity_d = even_parity(head_s);
`endif
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = {BAUD_W{1'b0}};
      end
    endcase
  end

  // Output logic: line level follows the state being entered so tx is a
  // plain register with no combinational path to the pins.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:   tx_d = 1'b1;
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef ALARM_TX_PARITY_EN
      PARITY: tx_d = parity_d;
`endif
      STOP:   tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || (count_next_s != {CW{1'b0}});
    ovf_d  = bus.code_valid && !push_s;
  end

  // Registered outputs; reset forces the line high immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;
  assign bus.fifo_count = count_s;

endmodule

// File: tb/tb_alarm_code_tx.sv
// tb_alarm_code_tx: directed stimulus for alarm_code_tx with a frame-level
// reference model (queue of pending codes + bit array of the frame in flight)
// compared against the DUT on every falling clock edge, plus hand-computed
// line sequences and counts. Honors ALARM_TX_PARITY_EN like the design.
module tb_alarm_code_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef ALARM_TX_PARITY_EN
  localparam int FB = 6;
`else
  localparam int FB = 5;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  alarm_code_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  alarm_code_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]    mq[$];
  logic [FB-1:0] m_frame;
  int            m_pos = 0;
  bit            m_fly = 1'b0;
  logic          m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0;
  int            m_cnt = 0;
  bit            m_fend, m_pop, m_push;

  function automatic logic [FB-1:0] build_frame(input logic [2:0] c);
    logic [FB-1:0] f;
    f[0] = 1'b0;
    f[1] = c[0];
    f[2] = c[1];
    f[3] = c[2];
`ifdef ALARM_TX_PARITY_EN
    f[4] = c[0] ^ c[1] ^ c[2];
`endif
    f[FB-1] = 1'b1;
    return f;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_fly = 1'b0; m_pos = 0;
      m_tx = 1'b1; m_busy = 1'b0; m_ovf = 1'b0; m_cnt = 0;
    end else begin
      m_fend = m_fly && (m_pos == FB*CPB - 1);
      m_pop  = (!m_fly || m_fend) && (mq.size() > 0);
      m_push = bus.code_valid && ((mq.size() < DEPTH) || m_pop);
      m_ovf  = bus.code_valid && !m_push;
      if (m_fly) m_pos++;
      if (m_fend) m_fly = 1'b0;
      if (m_pop) begin
        m_frame = build_frame(mq.pop_front());
        m_pos = 0;
        m_fly = 1'b1;
      end
      if (m_push) mq.push_back(bus.code_in);
      m_tx   = m_fly ? m_frame[m_pos / CPB] : 1'b1;
      m_busy = m_fly || (mq.size() != 0);
      m_cnt  = mq.size();
    end
  end

  always @(negedge clk) begin
    check("model_tx",         bus.tx,         m_tx);
    check("model_busy",       bus.busy,       m_busy);
    check("model_overflow",   bus.overflow,   m_ovf);
    check("model_fifo_count", bus.fifo_count, m_cnt);
  end

  // ---------------- directed stimulus ----------------
  task automatic send_frame(input logic [2:0] c, input logic [FB-1:0] exp_lit, input string nm);
    int busy_cyc = 0;
    @(posedge clk); #1;
    bus.code_in = c; bus.code_valid = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    for (int k = 0; k <= FB*CPB + 1; k++) begin
      @(negedge clk);
      if (k >= 1 && k <= FB*CPB) check(nm, bus.tx, exp_lit[(k-1)/CPB]);
      if (bus.busy === 1'b1) busy_cyc++;
    end
    check({nm, "_busy_len"}, busy_cyc, FB*CPB + 1);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(nm, bus.busy, 0);
  endtask

  initial begin
    logic [FB-1:0] lit;
    int busy_cyc, viol;
    bus.code_in = 3'd0;
    bus.code_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", bus.tx, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_count", bus.fifo_count, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_tx", bus.tx, 1);
    check("idle_overflow", bus.overflow, 0);

    // single code 3'b101
`ifdef ALARM_TX_PARITY_EN
    lit = 6'b101010;
`else
    lit = 5'b11010;
`endif
    send_frame(3'b101, lit, "single_101");

    // back-to-back 3'b001 then 3'b110
    @(posedge clk); #1;
    bus.code_in = 3'b001; bus.code_valid = 1'b1;
    @(posedge clk); #1;
    bus.code_in = 3'b110;
    @(negedge clk);
    busy_cyc = (bus.busy === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    for (int k = 1; k <= 2*FB*CPB + 1; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_cyc++;
      if (k == FB*CPB) check("b2b_stop1", bus.tx, 1);
      if (k == FB*CPB + 1) check("b2b_start2", bus.tx, 0);
    end
    check("b2b_busy_len", busy_cyc, 2*FB*CPB + 1);

    // overflow: six strobes on consecutive cycles
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      bus.code_in = 3'(i + 1); bus.code_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    @(negedge clk);
    check("ovf_pulse", bus.overflow, 1);
    check("ovf_count", bus.fifo_count, 4);
    @(negedge clk);
    check("ovf_single", bus.overflow, 0);

    // full FIFO with a strobe on the STOP->START pop edge
    repeat (FB*CPB - 6) @(posedge clk);
    #1;
    bus.code_in = 3'b011; bus.code_valid = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    @(negedge clk);
    check("fullpop_count", bus.fifo_count, 4);
    check("fullpop_overflow", bus.overflow, 0);
    check("fullpop_start", bus.tx, 0);
    drain("drain_after_full");

    // reset during DATA bit 1 of 3'b101 with one more code pending
    @(posedge clk); #1;
    bus.code_in = 3'b101; bus.code_valid = 1'b1;
    @(posedge clk); #1;
    bus.code_in = 3'b011;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("pre_rst_bit1", bus.tx, 0);
    check("pre_rst_count", bus.fifo_count, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_tx", bus.tx, 1);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_count", bus.fifo_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    viol = 0;
    for (int k = 0; k < 3*FB*CPB; k++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) viol++;
    end
    check("post_rst_quiet", viol, 0);

    // code 3'b111
`ifdef ALARM_TX_PARITY_EN
    lit = 6'b111110;
`else
    lit = 5'b11110;
`endif
    send_frame(3'b111, lit, "code_111");
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
